// File: rtl/program_loader_pkg.sv
// Shared types and defaults for the serial program loader.
package program_loader_pkg;

  localparam int unsigned NUM_WORDS_DEF = 8;
  localparam int unsigned ADDR_W_DEF    = 3;

  localparam int unsigned COND_W   = 2;
  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned DEST_W   = 3;
  localparam int unsigned SRC_W    = 3;
  localparam int unsigned SRC2_W   = 4;
  localparam int unsigned INSTR_W  = COND_W + OPCODE_W + DEST_W + SRC_W + SRC2_W;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_HI,
    LOAD_LO,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } state_t;

  typedef struct packed {
    logic [COND_W-1:0]   cond;
    logic [OPCODE_W-1:0] opcode;
    logic [DEST_W-1:0]   dest;
    logic [SRC_W-1:0]    source;
    logic [SRC2_W-1:0]   source2;
  } instr_t;

endpackage

// File: rtl/program_loader_checksum.sv
// Running 8-bit XOR checksum over accepted image bytes.
module loader_checksum (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] byte_in,
  output logic [7:0] sum
);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (enable) begin
      sum <= sum ^ byte_in;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a fixed-size program image from a byte stream into instruction
// memory, verifies a trailing XOR checksum and holds the CPU until done.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned NUM_WORDS = NUM_WORDS_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  if (NUM_WORDS != 2**ADDR_W) begin : g_bad_cfg
    $error("program_loader: NUM_WORDS must equal 2**ADDR_W");
  end

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  state_t     state_q, state_d;
  logic [7:0] hi_q;
  instr_t     word_q;
  logic [7:0] checksum;
  logic       accept;
  logic       start_load;
  logic       sum_en;

  assign accept     = byte_valid && byte_ready;
  assign start_load = start && (state_q == IDLE || state_q == DONE || state_q == ERROR);
  assign sum_en     = accept && (state_q == LOAD_HI || state_q == LOAD_LO);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD_HI;
      end
      LOAD_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) state_d = LOAD_LO;
      end
      LOAD_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) state_d = WRITE;
      end
      WRITE: begin
        wr_en   = 1'b1;
        state_d = (wr_addr == LAST_ADDR) ? CHECK : LOAD_HI;
      end
      CHECK: begin
        byte_ready = 1'b1;
        if (byte_valid) state_d = (byte_in == checksum) ? DONE : ERROR;
      end
      DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) state_d = LOAD_HI;
      end
      ERROR: begin
        error = 1'b1;
        if (start) state_d = LOAD_HI;
      end
      default: state_d = IDLE;
    endcase
  end

  // word_count doubles as the next write address; its extra bit keeps the
  // address from wrapping while wr_addr holds the last written location.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hi_q       <= '0;
      word_q     <= '0;
      wr_addr    <= '0;
      word_count <= '0;
    end else begin
      if (start_load) begin
        wr_addr    <= '0;
        word_count <= '0;
      end
      if (state_q == LOAD_HI && accept) begin
        hi_q <= byte_in;
      end
      if (state_q == LOAD_LO && accept) begin
        word_q  <= instr_t'({hi_q, byte_in});
        wr_addr <= word_count[ADDR_W-1:0];
      end
      if (state_q == WRITE) begin
        word_count <= word_count + {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end

  assign wr_data = word_q;

  loader_checksum u_checksum (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (start_load),
    .enable  (sum_en),
    .byte_in (byte_in),
    .sum     (checksum)
  );

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter NUM_WORDS, default 8, number of 16-bit instruction words per program image (matches the 3-bit program counter range).
REQ-002 Parameter ADDR_W, default 3, instruction-memory address width; NUM_WORDS SHALL equal 2**ADDR_W.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 Ports SHALL be:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle request to begin a load.
- byte_in  in  8  serial program byte.
- byte_valid  in  1  byte_in holds a byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction-memory write strobe.
- wr_addr  out  ADDR_W  instruction-memory write address.
- wr_data  out  16  instruction word {cond,opcode,dest,source,source2}.
- cpu_hold  out  1  holds the CPU fetch/decode/execute FSM while high.
- done  out  1  image loaded and checksum good.
- error  out  1  checksum mismatch.
- word_count  out  ADDR_W+1  words written in the current load.

Function
REQ-005 A byte SHALL be accepted only on a rising edge with byte_valid=1 and byte_ready=1.
REQ-006 States SHALL be IDLE, LOAD_HI, LOAD_LO, WRITE, CHECK, DONE and ERROR.
REQ-007 byte_ready SHALL be a Moore output: 1 only in LOAD_HI, LOAD_LO and CHECK.
REQ-008 IDLE, DONE or ERROR with start=1 SHALL go to LOAD_HI and clear the address, word_count, checksum, done and error; start in any other state SHALL be ignored.
REQ-009 LOAD_HI on acceptance SHALL latch the high byte, XOR it into the checksum and go to LOAD_LO.
REQ-010 LOAD_LO on acceptance SHALL set wr_data={high,byte_in}, XOR byte_in into the checksum and go to WRITE.
REQ-011 WRITE SHALL assert wr_en for exactly one cycle with the current address; wr_en follows low-byte acceptance by one cycle.
REQ-012 After WRITE the address and word_count SHALL increment; the next state is CHECK if the written address was NUM_WORDS-1, otherwise LOAD_HI. The address SHALL never wrap within a load.
REQ-013 CHECK on acceptance SHALL compare byte_in with the 8-bit XOR of all 2*NUM_WORDS image bytes: equal goes to DONE, unequal goes to ERROR.
REQ-014 In DONE, done=1 and cpu_hold=0; in every other state, cpu_hold=1 and done=0.
REQ-015 In ERROR, error=1; in every other state, error=0.
REQ-016 byte_valid with byte_ready=0 SHALL be ignored and the byte SHALL NOT be consumed; gaps in byte_valid SHALL stall the FSM without side effects.
REQ-017 wr_data and wr_addr SHALL hold their last values outside WRITE.

Reset
REQ-018 reset_n=0 at a rising edge SHALL force IDLE, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0, word_count=0 and checksum=0.
REQ-019 Reset during any load state SHALL abort the load with no further wr_en; memory contents already written are then undefined for the CPU.

Structure
REQ-020 A shared package SHALL hold the state enum, NUM_WORDS/ADDR_W defaults and the instruction field widths (cond 2, opcode 4, dest 3, source 3, source2 4).
REQ-021 The checksum register and XOR update SHALL be one sub-module, loader_checksum, with clear, enable and byte inputs.

Verification
REQ-022 Reset: hold reset_n=0 for 2 cycles -> all outputs at the REQ-018 values, with cpu_hold=1.
REQ-023 Good load: pulse start, then stream bytes 0x10..0x1F and checksum 0x00 -> eight wr_en pulses at addresses 0..7 with data 0x1011, 0x1213 … 0x1E1F; then done=1, cpu_hold=0, word_count=8.
REQ-024 Bad checksum: same image with checksum 0x5A -> eight writes, then error=1, done=0 and cpu_hold=1; a new start clears error.
REQ-025 Back-pressure: drop byte_valid for 3 cycles between a high and low byte -> no wr_en until the low byte is accepted, and the data word is still correct.
REQ-026 Reset mid-load after 5 accepted bytes -> IDLE next cycle, no further wr_en, word_count=0.
REQ-027 Restart from DONE: start, then a second image -> cpu_hold=1 the cycle after start, the new data is written and done=1 again.
